// File: rtl/turbo_rsc_encoder_pkg.sv
// Shared definitions for the turbo RSC encoder: FSM states, block sizes,
// tail length and bit-counter width.
package turbo_rsc_encoder_pkg;

    localparam int unsigned K_1056         = 1056;
    localparam int unsigned K_6144         = 6144;
    localparam int unsigned TAIL_CYCLES    = 6;
    localparam int unsigned TAIL_PHASE_LEN = TAIL_CYCLES / 2;
    localparam int unsigned CNT_W          = 13;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DATA  = 3'd1,
        ST_TAIL1 = 3'd2,
        ST_TAIL2 = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/turbo_rsc_encoder_rsc_constituent.sv
// One 8-state recursive systematic convolutional encoder,
// feedback g0 = 1+D^2+D^3, feedforward g1 = 1+D+D^3.
// When terminating, the input is replaced by the feedback value so the
// register fills with zeros; tail_bit is that substituted input.
module rsc_constituent
    import turbo_rsc_encoder_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic advance,
    input  logic terminate,
    input  logic c,
    output logic parity,
    output logic tail_bit
);

    // s_q = {s1, s2, s3}
    logic [2:0] s_q;
    logic [2:0] s_d;
    logic       fb;
    logic       c_eff;
    logic       a;

    assign fb       = s_q[1] ^ s_q[0];
    assign c_eff    = terminate ? fb : c;
    assign a        = c_eff ^ fb;
    assign parity   = a ^ s_q[2] ^ s_q[0];
    assign tail_bit = fb;

    // Next state: clear at block start, otherwise shift in the feedback bit when advancing.
    always_comb begin
        s_d = s_q;
        if (clear) begin
            s_d = 3'b000;
        end else if (advance) begin
            s_d = {a, s_q[2], s_q[1]};
        end
    end

    // Encoder shift register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s_q <= 3'b000;
        end else begin
            s_q <= s_d;
        end
    end

endmodule

// File: rtl/turbo_rsc_encoder.sv
// Turbo encoder core: two RSC constituents fed with natural-order (ci) and
// interleaved (cpii) bits, followed by trellis termination of encoder 1 then
// encoder 2. All outputs are registered, one cycle after the accepted input.
module turbo_rsc_encoder
    import turbo_rsc_encoder_pkg::*;
#(
    parameter int unsigned K_SMALL = K_1056,
    parameter int unsigned K_LARGE = K_6144
) (
    input  logic clock,
    input  logic reset_n,
    input  logic start,
    input  logic k_size_6144,
    input  logic in_valid,
    input  logic ci,
    input  logic cpii,
    output logic out_valid,
    output logic xk,
    output logic zk,
    output logic zpk,
    output logic tail,
    output logic busy,
    output logic done
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   k_q, k_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         tcnt_q, tcnt_d;

    logic out_valid_q, out_valid_d;
    logic xk_q, xk_d;
    logic zk_q, zk_d;
    logic zpk_q, zpk_d;
    logic tail_q, tail_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic clr;
    logic adv1, adv2;
    logic term1, term2;
    logic p1, p2;
    logic tb1, tb2;

    rsc_constituent u_enc1 (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (clr),
        .advance   (adv1),
        .terminate (term1),
        .c         (ci),
        .parity    (p1),
        .tail_bit  (tb1)
    );

    rsc_constituent u_enc2 (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (clr),
        .advance   (adv2),
        .terminate (term2),
        .c         (cpii),
        .parity    (p2),
        .tail_bit  (tb2)
    );

    // Next-state, encoder control and next output values for the block sequencer.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        cnt_d       = cnt_q;
        tcnt_d      = tcnt_q;
        clr         = 1'b0;
        adv1        = 1'b0;
        adv2        = 1'b0;
        term1       = 1'b0;
        term2       = 1'b0;
        out_valid_d = 1'b0;
        xk_d        = 1'b0;
        zk_d        = 1'b0;
        zpk_d       = 1'b0;
        tail_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_DATA;
                    k_d     = k_size_6144 ? CNT_W'(K_LARGE) : CNT_W'(K_SMALL);
                    cnt_d   = '0;
                    clr     = 1'b1;
                end
            end
            ST_DATA: begin
                if (in_valid) begin
                    adv1        = 1'b1;
                    adv2        = 1'b1;
                    out_valid_d = 1'b1;
                    xk_d        = ci;
                    zk_d        = p1;
                    zpk_d       = p2;
                    if (cnt_q == k_q - CNT_W'(1)) begin
                        state_d = ST_TAIL1;
                        tcnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_TAIL1: begin
                adv1        = 1'b1;
                term1       = 1'b1;
                out_valid_d = 1'b1;
                tail_d      = 1'b1;
                xk_d        = tb1;
                zk_d        = p1;
                if (tcnt_q == 2'(TAIL_PHASE_LEN - 1)) begin
                    state_d = ST_TAIL2;
                    tcnt_d  = '0;
                end else begin
                    tcnt_d = tcnt_q + 2'd1;
                end
            end
            ST_TAIL2: begin
                adv2        = 1'b1;
                term2       = 1'b1;
                out_valid_d = 1'b1;
                tail_d      = 1'b1;
                xk_d        = tb2;
                zpk_d       = p2;
                if (tcnt_q == 2'(TAIL_PHASE_LEN - 1)) begin
                    state_d = ST_DONE;
                    tcnt_d  = '0;
                end else begin
                    tcnt_d = tcnt_q + 2'd1;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Control state and registered outputs; reset aborts any block in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            cnt_q       <= '0;
            tcnt_q      <= '0;
            out_valid_q <= 1'b0;
            xk_q        <= 1'b0;
            zk_q        <= 1'b0;
            zpk_q       <= 1'b0;
            tail_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            tcnt_q      <= tcnt_d;
            out_valid_q <= out_valid_d;
            xk_q        <= xk_d;
            zk_q        <= zk_d;
            zpk_q       <= zpk_d;
            tail_q      <= tail_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out_valid = out_valid_q;
    assign xk        = xk_q;
    assign zk        = zk_q;
    assign zpk       = zpk_q;
    assign tail      = tail_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_turbo_rsc_encoder.sv
// Directed bench for turbo_rsc_encoder: all-zero, impulse, random with stalls,
// ignored restart, mid-block reset, and tail termination for both block sizes.
module tb_turbo_rsc_encoder;

    logic clock = 1'b0;
    logic reset_n;
    logic start;
    logic k_size_6144;
    logic in_valid;
    logic ci;
    logic cpii;
    logic out_valid;
    logic xk;
    logic zk;
    logic zpk;
    logic tail;
    logic busy;
    logic done;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    turbo_rsc_encoder dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .k_size_6144 (k_size_6144),
        .in_valid    (in_valid),
        .ci          (ci),
        .cpii        (cpii),
        .out_valid   (out_valid),
        .xk          (xk),
        .zk          (zk),
        .zpk         (zpk),
        .tail        (tail),
        .busy        (busy),
        .done        (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference RSC step on state {s1,s2,s3}: returns {z, next_state}.
    function automatic logic [3:0] rsc_step(input logic [2:0] st, input logic c);
        logic s1, s2, s3, a, z;
        s1 = st[2];
        s2 = st[1];
        s3 = st[0];
        a  = c ^ s2 ^ s3;
        z  = a ^ s1 ^ s3;
        return {z, a, s1, s2};
    endfunction

    // Entered and left #1 after a rising edge.
    task automatic run_block(input logic big, input int pattern, input bit stall,
                             input int restart_at, input int abort_at);
        int         k;
        int         acc;
        int         edges;
        int         n_ov;
        int         nz;
        logic [2:0] m1;
        logic [2:0] m2;
        logic [3:0] r1;
        logic [3:0] r2;
        logic [4:0] zfirst;
        logic       c1, c2, iv, ex, ez;

        k      = big ? 6144 : 1056;
        acc    = 0;
        edges  = 0;
        n_ov   = 0;
        nz     = 0;
        m1     = 3'b000;
        m2     = 3'b000;
        zfirst = 5'b00000;

        start       = 1'b1;
        k_size_6144 = big;
        in_valid    = 1'b0;
        @(posedge clock); #1;
        start       = 1'b0;
        k_size_6144 = ~big;
        chk("busy_after_start", busy, 1);
        chk("ov_after_start", out_valid, 0);

        while (acc < k) begin
            iv = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pattern == 2) begin
                c1 = 1'($urandom_range(0, 1));
                c2 = 1'($urandom_range(0, 1));
            end else begin
                c1 = (pattern == 1) && (acc == 0);
                c2 = 1'b0;
            end
            in_valid = iv;
            ci       = c1;
            cpii     = c2;
            start    = (acc == restart_at);

            if (acc == abort_at && iv) begin
                reset_n = 1'b0;
                #1;
                chk("abort_ov", out_valid, 0);
                chk("abort_xk", xk, 0);
                chk("abort_zk", zk, 0);
                chk("abort_zpk", zpk, 0);
                chk("abort_tail", tail, 0);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                start = 1'b0;
                @(posedge clock); #1;
                reset_n = 1'b1;
                for (int i = 0; i < 20; i++) begin
                    in_valid = 1'b1;
                    ci       = 1'($urandom_range(0, 1));
                    @(posedge clock); #1;
                    chk("post_abort_done", done, 0);
                    chk("post_abort_ov", out_valid, 0);
                end
                in_valid = 1'b0;
                return;
            end

            @(posedge clock); #1;
            start = 1'b0;
            if (iv || acc > 0) edges++;
            if (iv) begin
                r1 = rsc_step(m1, c1);
                r2 = rsc_step(m2, c2);
                m1 = r1[2:0];
                m2 = r2[2:0];
                chk("data_ov", out_valid, 1);
                chk("data_xk", xk, c1);
                chk("data_zk", zk, r1[3]);
                chk("data_zpk", zpk, r2[3]);
                chk("data_tail", tail, 0);
                if (nz < 5) begin
                    zfirst = {zfirst[3:0], zk};
                    nz++;
                end
                acc++;
            end else begin
                chk("stall_ov", out_valid, 0);
            end
            if (out_valid) n_ov++;
            chk("data_busy", busy, 1);
            chk("data_done", done, 0);
        end

        for (int t = 0; t < 6; t++) begin
            in_valid = 1'($urandom_range(0, 1));
            ci       = 1'($urandom_range(0, 1));
            cpii     = 1'($urandom_range(0, 1));
            @(posedge clock); #1;
            edges++;
            if (out_valid) n_ov++;
            if (t < 3) begin
                ex = m1[1] ^ m1[0];
                ez = m1[2] ^ m1[0];
                m1 = {1'b0, m1[2], m1[1]};
                chk("tail1_xk", xk, ex);
                chk("tail1_zk", zk, ez);
                chk("tail1_zpk", zpk, 0);
            end else begin
                ex = m2[1] ^ m2[0];
                ez = m2[2] ^ m2[0];
                m2 = {1'b0, m2[2], m2[1]};
                chk("tail2_xk", xk, ex);
                chk("tail2_zpk", zpk, ez);
                chk("tail2_zk", zk, 0);
            end
            chk("tail_flag", tail, 1);
            chk("tail_ov", out_valid, 1);
            chk("tail_done", done, 0);
        end
        chk("enc1_terminal", dut.u_enc1.s_q, 0);
        chk("enc2_terminal", dut.u_enc2.s_q, 0);

        in_valid = 1'b0;
        @(posedge clock); #1;
        edges++;
        chk("done_pulse", done, 1);
        chk("done_ov", out_valid, 0);
        chk("done_tail", tail, 0);
        chk("ov_count", n_ov, k + 6);
        if (!stall) chk("done_latency", edges, k + 7);
        if (pattern == 1) chk("impulse_zk5", zfirst, 5'b11110);

        @(posedge clock); #1;
        chk("done_clear", done, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        k_size_6144 = 1'b0;
        in_valid    = 1'b0;
        ci          = 1'b0;
        cpii        = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_ov", out_valid, 0);
        chk("rst_xk", xk, 0);
        chk("rst_zk", zk, 0);
        chk("rst_zpk", zpk, 0);
        chk("rst_tail", tail, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            ci       = 1'b1;
            cpii     = 1'b1;
            @(posedge clock); #1;
            chk("idle_ignore_ov", out_valid, 0);
            chk("idle_ignore_busy", busy, 0);
        end
        in_valid = 1'b0;

        run_block(1'b0, 0, 1'b0, -1, -1);
        run_block(1'b0, 1, 1'b0, -1, -1);
        run_block(1'b1, 2, 1'b1, -1, -1);
        run_block(1'b0, 2, 1'b0, 300, -1);
        run_block(1'b0, 2, 1'b1, -1, 500);
        run_block(1'b0, 2, 1'b0, -1, -1);
        run_block(1'b1, 2, 1'b0, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
